// File: rtl/mem_byte_responder.sv
// Byte-wide external bus responder: serves core fetches, word/byte reads and
// byte-masked writes as a sequence of wait-stated byte beats, then pulses done.
module mem_byte_responder #(
  parameter int RV   = 32,
  parameter int VA   = RV,
  parameter int WAIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [VA-2:0]        pc,
  input  logic                 ifetch,
  input  logic [VA-RV/16-1:0]  addr,
  input  logic [1:0]           rstrobe,
  input  logic [RV/8-1:0]      wmask,
  input  logic [RV-1:0]        wdata,
  input  logic                 io_access,
  output logic                 idone,
  output logic [15:0]          idata,
  output logic                 rdone,
  output logic [RV-1:0]        rdata,
  output logic                 wdone,
  output logic [VA-1:0]        mem_a,
  output logic [7:0]           mem_d_out,
  input  logic [7:0]           mem_d_in,
  output logic                 mem_oe,
  output logic                 mem_we,
  output logic                 io_sel
);

  localparam int NB  = RV / 8;
  localparam int LW  = $clog2(NB);
  localparam int LCW = LW + 1;

  localparam logic [2:0]    WAIT3      = 3'(WAIT);
  localparam logic [NB-1:0] FETCH_MASK = NB'(2'b11);
  localparam logic [NB-1:0] ALL_MASK   = {NB{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_t;

  function automatic logic [LCW-1:0] first_set(input logic [NB-1:0] m);
    logic [LCW-1:0] r;
    r = {LCW{1'b0}};
    for (int i = NB - 1; i >= 0; i--) begin
      if (m[i]) r = LCW'(i);
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] lane_bit(input logic [LCW-1:0] idx);
    logic [NB-1:0] r;
    r = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      if (idx == LCW'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [RV-1:0] w, input logic [LCW-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (idx == LCW'(i)) r = w[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [RV-1:0] put_byte(input logic [RV-1:0] w, input logic [LCW-1:0] idx,
                                             input logic [7:0] b);
    logic [RV-1:0] r;
    r = w;
    for (int i = 0; i < NB; i++) begin
      if (idx == LCW'(i)) r[8*i +: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [VA-1:0] lane_addr(input logic [VA-1:0] base, input logic [LCW-1:0] idx);
    return base + {{(VA-LCW){1'b0}}, idx};
  endfunction

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [VA-1:0]   base_q, base_d;
  logic [RV-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]   pend_q, pend_d;
  logic [LCW-1:0]  lane_q, lane_d;
  logic [1:0]      rstrobe_q, rstrobe_d;
  logic            io_q, io_d;
  logic [2:0]      wait_q, wait_d;
  logic            gap_q, gap_d;
  logic [RV-1:0]   word_q, word_d;
  logic            idone_q, idone_d, rdone_q, rdone_d, wdone_q, wdone_d;
  logic [15:0]     idata_q, idata_d;
  logic [RV-1:0]   rdata_q, rdata_d;
  logic [VA-1:0]   mem_a_q, mem_a_d;
  logic [7:0]      mem_d_out_q, mem_d_out_d;
  logic            mem_oe_q, mem_oe_d, mem_we_q, mem_we_d, io_sel_q, io_sel_d;

  logic            req_valid_s;
  kind_t           req_kind_s;
  logic [VA-1:0]   req_base_s;
  logic [NB-1:0]   req_pend_s;
  logic            req_io_s;
  logic [LCW-1:0]  req_lane_s;
  logic [NB-1:0]   pend_nx_s;
  logic [LCW-1:0]  lane_nx_s;
  logic [RV-1:0]   word_nx_s;

  // Arbitration: write beats read beats fetch; losers simply stay pending.
  always_comb begin
    req_valid_s = 1'b1;
    req_kind_s  = K_FETCH;
    req_base_s  = {pc, 1'b0};
    req_pend_s  = FETCH_MASK;
    req_io_s    = 1'b0;
    if (|wmask) begin
      req_kind_s = K_WRITE;
      req_base_s = {addr, {(RV/16){1'b0}}};
      req_pend_s = wmask;
      req_io_s   = io_access;
    end else if (|rstrobe) begin
      req_kind_s = K_READ;
      req_base_s = {addr, {(RV/16){1'b0}}};
      req_pend_s = ALL_MASK;
      req_io_s   = io_access;
    end else if (ifetch) begin
      req_kind_s = K_FETCH;
    end else begin
      req_valid_s = 1'b0;
    end
    req_lane_s = first_set(req_pend_s);
  end

  // End-of-beat bookkeeping: remaining lanes, next lane and the assembled word.
  always_comb begin
    pend_nx_s = pend_q & ~lane_bit(lane_q);
    lane_nx_s = first_set(pend_nx_s);
    word_nx_s = put_byte(word_q, lane_q, mem_d_in);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    pend_d      = pend_q;
    lane_d      = lane_q;
    rstrobe_d   = rstrobe_q;
    io_d        = io_q;
    wait_d      = wait_q;
    gap_d       = gap_q;
    word_d      = word_q;
    idone_d     = 1'b0;
    rdone_d     = 1'b0;
    wdone_d     = 1'b0;
    idata_d     = idata_q;
    rdata_d     = rdata_q;
    mem_a_d     = mem_a_q;
    mem_d_out_d = mem_d_out_q;
    mem_oe_d    = mem_oe_q;
    mem_we_d    = mem_we_q;
    io_sel_d    = io_sel_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_s) begin
          state_d   = S_BEAT;
          kind_d    = req_kind_s;
          base_d    = req_base_s;
          pend_d    = req_pend_s;
          lane_d    = req_lane_s;
          wdata_d   = wdata;
          rstrobe_d = rstrobe;
          io_d      = req_io_s;
          wait_d    = WAIT3;
          gap_d     = 1'b0;
          mem_a_d   = lane_addr(req_base_s, req_lane_s);
          mem_we_d  = (req_kind_s == K_WRITE);
          mem_oe_d  = (req_kind_s != K_WRITE);
          io_sel_d  = req_io_s;
          if (req_kind_s == K_WRITE) begin
            mem_d_out_d = get_byte(wdata, req_lane_s);
          end else begin
            mem_d_out_d = mem_d_out_q;
          end
        end else begin
          mem_oe_d = 1'b0;
          mem_we_d = 1'b0;
          io_sel_d = 1'b0;
        end
      end
      S_BEAT: begin
        if (gap_q) begin
          // Address and data were set up during the gap; now strobe the write.
          gap_d    = 1'b0;
          mem_we_d = 1'b1;
        end else if (wait_q != 3'd0) begin
          wait_d = wait_q - 3'd1;
        end else begin
          if (kind_q != K_WRITE) begin
            word_d = word_nx_s;
          end else begin
            word_d = word_q;
          end
          if (pend_nx_s == {NB{1'b0}}) begin
            state_d  = S_DONE;
            pend_d   = {NB{1'b0}};
            lane_d   = {LCW{1'b0}};
            mem_oe_d = 1'b0;
            mem_we_d = 1'b0;
            io_sel_d = 1'b0;
            case (kind_q)
              K_FETCH: begin
                idone_d = 1'b1;
                idata_d = word_nx_s[15:0];
              end
              K_READ: begin
                rdone_d = 1'b1;
                rdata_d = (rstrobe_q == 2'b10) ? {8'h00, word_nx_s[RV-1:8]} : word_nx_s;
              end
              K_WRITE: wdone_d = 1'b1;
              default: state_d = S_IDLE;
            endcase
          end else begin
            pend_d  = pend_nx_s;
            lane_d  = lane_nx_s;
            wait_d  = WAIT3;
            mem_a_d = lane_addr(base_q, lane_nx_s);
            if (kind_q == K_WRITE) begin
              mem_d_out_d = get_byte(wdata_q, lane_nx_s);
              mem_we_d    = 1'b0;
              gap_d       = 1'b1;
            end else begin
              mem_d_out_d = mem_d_out_q;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        mem_oe_d = 1'b0;
        mem_we_d = 1'b0;
        io_sel_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without a done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= K_FETCH;
      base_q      <= {VA{1'b0}};
      wdata_q     <= {RV{1'b0}};
      pend_q      <= {NB{1'b0}};
      lane_q      <= {LCW{1'b0}};
      rstrobe_q   <= 2'b00;
      io_q        <= 1'b0;
      wait_q      <= 3'd0;
      gap_q       <= 1'b0;
      word_q      <= {RV{1'b0}};
      idone_q     <= 1'b0;
      rdone_q     <= 1'b0;
      wdone_q     <= 1'b0;
      idata_q     <= 16'h0000;
      rdata_q     <= {RV{1'b0}};
      mem_a_q     <= {VA{1'b0}};
      mem_d_out_q <= 8'h00;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      io_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      pend_q      <= pend_d;
      lane_q      <= lane_d;
      rstrobe_q   <= rstrobe_d;
      io_q        <= io_d;
      wait_q      <= wait_d;
      gap_q       <= gap_d;
      word_q      <= word_d;
      idone_q     <= idone_d;
      rdone_q     <= rdone_d;
      wdone_q     <= wdone_d;
      idata_q     <= idata_d;
      rdata_q     <= rdata_d;
      mem_a_q     <= mem_a_d;
      mem_d_out_q <= mem_d_out_d;
      mem_oe_q    <= mem_oe_d;
      mem_we_q    <= mem_we_d;
      io_sel_q    <= io_sel_d;
    end
  end

  assign idone     = idone_q;
  assign rdone     = rdone_q;
  assign wdone     = wdone_q;
  assign idata     = idata_q;
  assign rdata     = rdata_q;
  assign mem_a     = mem_a_q;
  assign mem_d_out = mem_d_out_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we    = mem_we_q;
  assign io_sel    = io_sel_q;

endmodule

// File: tb/tb_mem_byte_responder.sv
// Randomized bench for mem_byte_responder: a transaction-level model predicts
// the bus activity and done timing of every cycle, checked at each negedge.
module tb_mem_byte_responder;
  localparam int RV = 32;
  localparam int VA = 32;
  localparam int WAIT = 1;

  logic clk = 1'b0;
  logic reset;
  logic [30:0] pc;
  logic ifetch;
  logic [29:0] addr;
  logic [1:0] rstrobe;
  logic [3:0] wmask;
  logic [31:0] wdata;
  logic io_access;
  logic idone, rdone, wdone;
  logic [15:0] idata;
  logic [31:0] rdata;
  logic [31:0] mem_a;
  logic [7:0] mem_d_out, mem_d_in;
  logic mem_oe, mem_we, io_sel;

  mem_byte_responder #(.RV(RV), .VA(VA), .WAIT(WAIT)) dut (
    .clk(clk), .reset(reset), .pc(pc), .ifetch(ifetch), .addr(addr),
    .rstrobe(rstrobe), .wmask(wmask), .wdata(wdata), .io_access(io_access),
    .idone(idone), .idata(idata), .rdone(rdone), .rdata(rdata), .wdone(wdone),
    .mem_a(mem_a), .mem_d_out(mem_d_out), .mem_d_in(mem_d_in),
    .mem_oe(mem_oe), .mem_we(mem_we), .io_sel(io_sel)
  );

  always #5 clk = ~clk;

  // external byte memory seen by the DUT, and the model's own copy
  logic [7:0] bus_mem [0:255];
  logic [7:0] ref_mem [0:255];
  assign mem_d_in = bus_mem[mem_a[7:0]];
  always @(posedge clk) if (mem_we) bus_mem[mem_a[7:0]] = mem_d_out;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int cyc; bit chk_bus; bit oe; bit we; bit io; logic [31:0] a;
    bit chk_d; logic [7:0] d; bit id; bit rd; bit wd; logic [31:0] rdat; logic [15:0] idat;
  } exp_t;
  exp_t q[$];
  exp_t ce;

  int vecs = 0, errs = 0;
  bit chk_en = 1'b0, bad;
  int rdone_cnt = 0, idone_cnt = 0, wdone_cnt = 0, we_rise = 0;
  bit we_prev = 1'b0;
  int done_abs [3];
  int done_rel [3];
  logic [31:0] last_rdata;
  logic [15:0] last_idata;

  function automatic exp_t blank(input int c);
    exp_t e;
    e.cyc = c; e.chk_bus = 1'b1; e.oe = 1'b0; e.we = 1'b0; e.io = 1'b0; e.a = 32'h0;
    e.chk_d = 1'b0; e.d = 8'h00; e.id = 1'b0; e.rd = 1'b0; e.wd = 1'b0;
    e.rdat = 32'h0; e.idat = 16'h0;
    return e;
  endfunction

  // model: kind 2 = write, 1 = read, 0 = fetch; request sampled in cycle c0
  function automatic void build(input int kind, input int c0, input logic [29:0] a_w,
                                input logic [30:0] p, input logic [1:0] rs,
                                input logic [3:0] wm, input logic [31:0] wd, input bit io);
    exp_t e;
    int base, n, t, j;
    bit ioe;
    logic [31:0] word;
    t = c0 + 1;
    if (kind == 2) begin
      base = int'(a_w) * 4;
      j = 0;
      for (int ln = 0; ln < 4; ln++) begin
        if (wm[ln]) begin
          if (j > 0) begin
            e = blank(t); e.chk_bus = 1'b0; q.push_back(e); t++;
          end
          for (int w = 0; w <= WAIT; w++) begin
            e = blank(t); e.we = 1'b1; e.io = io; e.a = 32'(base + ln);
            e.chk_d = 1'b1; e.d = wd[8*ln +: 8]; q.push_back(e); t++;
          end
          ref_mem[base + ln] = wd[8*ln +: 8];
          j++;
        end
      end
      e = blank(t); e.wd = 1'b1; q.push_back(e);
    end else begin
      if (kind == 1) begin base = int'(a_w) * 4; n = 4; ioe = io; end
      else begin base = int'(p) * 2; n = 2; ioe = 1'b0; end
      word = 32'h0;
      for (int k = 0; k < n; k++) begin
        word[8*k +: 8] = ref_mem[base + k];
        for (int w = 0; w <= WAIT; w++) begin
          e = blank(t); e.oe = 1'b1; e.io = ioe; e.a = 32'(base + k); q.push_back(e); t++;
        end
      end
      e = blank(t);
      if (kind == 1) begin e.rd = 1'b1; e.rdat = (rs == 2'b10) ? (word >> 8) : word; end
      else begin e.id = 1'b1; e.idat = word[15:0]; end
      q.push_back(e);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // per-cycle compare against the model trace; idle expected when nothing is due
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) ce = q.pop_front();
      else ce = blank(cyc);
      bad = 1'b0;
      if (mem_oe !== ce.oe || mem_we !== ce.we || idone !== ce.id || rdone !== ce.rd || wdone !== ce.wd) bad = 1'b1;
      if (ce.chk_bus && io_sel !== ce.io) bad = 1'b1;
      if ((ce.oe || ce.we) && mem_a !== ce.a) bad = 1'b1;
      if (ce.chk_d && mem_d_out !== ce.d) bad = 1'b1;
      if (ce.rd && rdata !== ce.rdat) bad = 1'b1;
      if (ce.id && idata !== ce.idat) bad = 1'b1;
      vecs++;
      if (bad) begin
        errs++;
        $display("FAIL cycle %0d bus: got oe/we/io=%b%b%b a=%h d=%h i/r/wdone=%b%b%b rdata=%h idata=%h, expected oe/we/io=%b%b%b a=%h d=%h i/r/wdone=%b%b%b rdata=%h idata=%h",
                 cyc, mem_oe, mem_we, io_sel, mem_a, mem_d_out, idone, rdone, wdone, rdata, idata,
                 ce.oe, ce.we, ce.io, ce.a, ce.d, ce.id, ce.rd, ce.wd, ce.rdat, ce.idat);
      end
      if (rdone) rdone_cnt++;
      if (idone) idone_cnt++;
      if (wdone) wdone_cnt++;
      if (mem_we && !we_prev) we_rise++;
      we_prev = mem_we;
    end
  end

  task automatic wait_done(input int kind, output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((kind == 2 && wdone === 1'b1) || (kind == 1 && rdone === 1'b1) || (kind == 0 && idone === 1'b1)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      errs++;
      $display("FAIL timeout waiting for done of kind %0d: got none expected a pulse", kind);
      q.delete();
    end
  endtask

  task automatic run_group(input logic [29:0] a_w, input logic [30:0] p, input bit f,
                           input logic [1:0] rs, input logic [3:0] wm, input logic [31:0] wd, input bit io);
    int c0;
    bit got;
    c0 = cyc;
    addr = a_w; pc = p; ifetch = f; rstrobe = rs; wmask = wm; wdata = wd; io_access = io;
    for (int k = 2; k >= 0; k--) begin
      if ((k == 2 && wm != 4'h0) || (k == 1 && rs != 2'b00) || (k == 0 && f)) begin
        build(k, c0, a_w, p, rs, wm, wd, io);
        wait_done(k, got);
        done_abs[k] = cyc;
        done_rel[k] = cyc - c0;
        if (k == 1) last_rdata = rdata;
        if (k == 0) last_idata = idata;
        @(posedge clk); #1;
        if (k == 2) wmask = 4'h0;
        else if (k == 1) rstrobe = 2'b00;
        else ifetch = 1'b0;
        c0 = cyc;
      end
    end
  endtask

  task automatic set_byte(input int a, input logic [7:0] b);
    bus_mem[a] = b;
    ref_mem[a] = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0, w0, i0;
    logic [3:0] wm;
    logic [1:0] rs;
    bit f;
    reset = 1'b1; pc = '0; ifetch = 1'b0; addr = '0; rstrobe = 2'b00; wmask = 4'h0;
    wdata = 32'h0; io_access = 1'b0;
    for (int i = 0; i < 256; i++) set_byte(i, 8'($urandom_range(0, 255)));
    set_byte(8'h40, 8'h11); set_byte(8'h41, 8'h22); set_byte(8'h42, 8'h33); set_byte(8'h43, 8'h44);
    repeat (3) @(posedge clk);
    #1;
    chk("reset idone", {31'h0, idone}, 32'h0);
    chk("reset rdone", {31'h0, rdone}, 32'h0);
    chk("reset wdone", {31'h0, wdone}, 32'h0);
    chk("reset strobes", {29'h0, mem_oe, mem_we, io_sel}, 32'h0);
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset mem_d_out", {24'h0, mem_d_out}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset idata", {16'h0, idata}, 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_group(30'h10, 31'h0, 1'b0, 2'b11, 4'h0, 32'h0, 1'b0);
    chk("word read rdata", last_rdata, 32'h44332211);
    chk("word read latency", 32'(done_rel[1]), 32'd9);
    run_group(30'h10, 31'h0, 1'b0, 2'b10, 4'h0, 32'h0, 1'b0);
    chk("odd byte rdata", last_rdata, 32'h00443322);
    run_group(30'h10, 31'h0, 1'b0, 2'b01, 4'h0, 32'h0, 1'b1);
    chk("low byte rdata", last_rdata, 32'h44332211);

    set_byte(8'h42, 8'hCD); set_byte(8'h43, 8'hAB);
    run_group(30'h0, 31'h21, 1'b1, 2'b00, 4'h0, 32'h0, 1'b1);
    chk("fetch idata", {16'h0, last_idata}, 32'h0000ABCD);
    chk("fetch latency", 32'(done_rel[0]), 32'd5);

    for (int i = 16; i < 20; i++) set_byte(i, 8'h5A);
    w0 = we_rise;
    run_group(30'h4, 31'h0, 1'b0, 2'b00, 4'b1010, 32'hAABBCCDD, 1'b1);
    chk("sparse write beats", 32'(we_rise - w0), 32'd2);
    chk("sparse write latency", 32'(done_rel[2]), 32'd6);
    chk("sparse byte 0x11", {24'h0, bus_mem[8'h11]}, 32'h000000CC);
    chk("sparse byte 0x13", {24'h0, bus_mem[8'h13]}, 32'h000000AA);
    chk("skipped byte 0x10", {24'h0, bus_mem[8'h10]}, 32'h0000005A);
    chk("skipped byte 0x12", {24'h0, bus_mem[8'h12]}, 32'h0000005A);

    w0 = wdone_cnt; i0 = idone_cnt;
    run_group(30'h8, 31'h10, 1'b1, 2'b00, 4'b0001, 32'h000000E7, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("write+fetch wdone count", 32'(wdone_cnt - w0), 32'd1);
    chk("write+fetch idone count", 32'(idone_cnt - i0), 32'd1);
    chk("fetch after write gap", 32'(done_abs[0] - done_abs[2]), 32'd6);
    chk("fetch sees written byte", {24'h0, last_idata[7:0]}, 32'h000000E7);

    // reset during beat 2 of a word read
    r0 = rdone_cnt;
    c0 = cyc;
    addr = 30'h10; rstrobe = 2'b11; io_access = 1'b0;
    build(1, c0, 30'h10, 31'h0, 2'b11, 4'h0, 32'h0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    @(posedge clk); #1;
    chk("mem_oe after reset", {31'h0, mem_oe}, 32'h0);
    reset = 1'b0;
    rstrobe = 2'b00;
    repeat (12) @(posedge clk);
    #1;
    chk("no rdone after reset", 32'(rdone_cnt - r0), 32'd0);
    run_group(30'h10, 31'h0, 1'b0, 2'b11, 4'h0, 32'h0, 1'b0);
    chk("read after reset", last_rdata, 32'hABCD2211);

    for (int n = 0; n < 40; n++) begin
      wm = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rs = 2'($urandom_range(0, 3));
      f = 1'($urandom_range(0, 1));
      if (wm == 4'h0 && rs == 2'b00 && !f) f = 1'b1;
      run_group(30'($urandom_range(0, 63)), 31'($urandom_range(0, 127)), f, rs, wm,
                $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
